// File: rtl/fetch_pkg.sv
// Shared phase encodings, reset instruction and FSM state type for the fetch sequencer.
package fetch_pkg;

  localparam int unsigned EN_W    = 4;
  localparam int unsigned INSTR_W = 32;

  localparam logic [EN_W-1:0] EN_FETCH = 4'b0000;
  localparam logic [EN_W-1:0] EN_DEC   = 4'b0001;
  localparam logic [EN_W-1:0] EN_EXE   = 4'b0010;
  localparam logic [EN_W-1:0] EN_MEM   = 4'b0100;
  localparam logic [EN_W-1:0] EN_WB    = 4'b1000;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {
    ST_RST,
    ST_FETCH,
    ST_DEC,
    ST_EXE,
    ST_MEM,
    ST_WB
  } state_e;

endpackage

// File: rtl/fetch_pc_next.sv
// Next-PC adder: sequential +4, or PC plus sign-extended B-type offset with the
// result word-aligned.
module fetch_pc_next #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] pc_i,
  input  logic            branch_taken_i,
  input  logic [11:0]     branch_offset_i,
  output logic [XLEN-1:0] pc_next_c
);

  localparam int unsigned     OFF_W      = 13;
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  logic [XLEN-1:0] off_ext;
  logic [XLEN-1:0] br_sum;

  // offset[12:1] from the decoder, implicit offset[0] = 0
  assign off_ext   = {{(XLEN-OFF_W){branch_offset_i[11]}}, branch_offset_i, 1'b0};
  assign br_sum    = pc_i + off_ext;
  assign pc_next_c = branch_taken_i ? (br_sum & ALIGN_MASK) : (pc_i + XLEN'(4));

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch and one-hot phase sequencer feeding the decoder.
// Optional retired-instruction counter enabled by FETCH_PERF_CNT_EN.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [11:0]     branch_offset,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] pc,
  output logic [3:0]      en,
  output logic            instr_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     instret
`endif
);

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic [EN_W-1:0] en_q, en_d;
  logic            req_q, req_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] pc_next_c;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0]     instret_q, instret_d;
`endif

  fetch_pc_next #(
    .XLEN (XLEN)
  ) u_pc_next (
    .pc_i            (pc_q),
    .branch_taken_i  (branch_taken),
    .branch_offset_i (branch_offset),
    .pc_next_c       (pc_next_c)
  );

  // Next-state and registered-output logic; stall holds every execute-side phase.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    en_d    = en_q;
    req_d   = 1'b0;
    valid_d = valid_q;
`ifdef FETCH_PERF_CNT_EN
    instret_d = instret_q;
`endif
    unique case (state_q)
      ST_RST: begin
        state_d = ST_FETCH;
        en_d    = EN_FETCH;
        req_d   = 1'b1;
      end
      ST_FETCH: begin
        en_d  = EN_FETCH;
        req_d = 1'b1;
        if (imem_ack) begin
          instr_d = imem_rdata;
          valid_d = 1'b1;
          state_d = ST_DEC;
          en_d    = EN_DEC;
          req_d   = 1'b0;
        end
      end
      ST_DEC: begin
        if (!stall) begin
          state_d = ST_EXE;
          en_d    = EN_EXE;
        end
      end
      ST_EXE: begin
        if (!stall) begin
          state_d = ST_MEM;
          en_d    = EN_MEM;
        end
      end
      ST_MEM: begin
        if (!stall) begin
          state_d = ST_WB;
          en_d    = EN_WB;
        end
      end
      ST_WB: begin
        if (!stall) begin
          pc_d    = pc_next_c;
          valid_d = 1'b0;
          state_d = ST_FETCH;
          en_d    = EN_FETCH;
          req_d   = 1'b1;
`ifdef FETCH_PERF_CNT_EN
          instret_d = instret_q + 32'd1;
`endif
        end
      end
      default: begin
        state_d = ST_RST;
        en_d    = EN_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_RST;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      en_q    <= EN_FETCH;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
`ifdef FETCH_PERF_CNT_EN
      instret_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      en_q    <= en_d;
      req_q   <= req_d;
      valid_q <= valid_d;
`ifdef FETCH_PERF_CNT_EN
      instret_q <= instret_d;
`endif
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign pc          = pc_q;
  assign en          = en_q;
  assign instr_valid = valid_q;
`ifdef FETCH_PERF_CNT_EN
  assign instret     = instret_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized self-checking bench for fetch_sequencer against an instruction-level PC model.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        branch_taken;
  logic [11:0] branch_offset;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [3:0]  en;
  logic        instr_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] instret;
`endif

  int total = 0;
  int bad   = 0;

  // Model: PC of the next instruction to fetch and number of instructions retired.
  logic [31:0] m_pc;
  logic [31:0] m_instret;

  always #5 clk = ~clk;

  fetch_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .instr         (instr),
    .pc            (pc),
    .en            (en),
    .instr_valid   (instr_valid)
`ifdef FETCH_PERF_CNT_EN
    ,
    .instret       (instret)
`endif
  );

  task automatic step();
    @(negedge clk);
  endtask

  // One complete instruction starting from the FETCH phase.
  task automatic run_instr(input int waits, input int st0, input int st1, input int st2,
                           input int st3, input bit take, input logic [11:0] off,
                           input logic [31:0] word);
    int stl[4];
    logic [3:0] exp_en;
    int byte_off;
    stl = '{st0, st1, st2, st3};
    total++;
    if (imem_req !== 1'b1 || imem_addr !== m_pc || en !== 4'b0000 || instr_valid !== 1'b0) begin
      bad++;
      $display("FAIL fetch_entry: req=%b addr=%h en=%b valid=%b, want req=1 addr=%h en=0000 valid=0",
               imem_req, imem_addr, en, instr_valid, m_pc);
    end
`ifdef FETCH_PERF_CNT_EN
    total++;
    if (instret !== m_instret) begin
      bad++;
      $display("FAIL instret: got %0d want %0d", instret, m_instret);
    end
`endif
    for (int w = 0; w < waits; w++) begin
      imem_ack      = 1'b0;
      imem_rdata    = $urandom;
      stall         = 1'($urandom % 2);
      branch_taken  = 1'($urandom % 2);
      branch_offset = 12'($urandom);
      step();
      total++;
      if (imem_req !== 1'b1 || imem_addr !== m_pc || en !== 4'b0000) begin
        bad++;
        $display("FAIL fetch_wait: req=%b addr=%h en=%b, want req=1 addr=%h en=0000",
                 imem_req, imem_addr, en, m_pc);
      end
    end
    imem_ack   = 1'b1;
    imem_rdata = word;
    stall      = 1'($urandom % 2);
    step();
    for (int p = 0; p < 4; p++) begin
      exp_en = 4'(1 << p);
      for (int s = 0; s <= stl[p]; s++) begin
        total++;
        if (en !== exp_en || instr !== word || pc !== m_pc || instr_valid !== 1'b1 ||
            imem_req !== 1'b0) begin
          bad++;
          $display("FAIL phase%0d: en=%b instr=%h pc=%h valid=%b req=%b, want en=%b instr=%h pc=%h valid=1 req=0",
                   p, en, instr, pc, instr_valid, imem_req, exp_en, word, m_pc);
        end
        stall         = (s < stl[p]);
        branch_taken  = (p == 3 && s == stl[p]) ? take : 1'($urandom % 2);
        branch_offset = (p == 3) ? off : 12'($urandom);
        imem_ack      = 1'($urandom % 2);
        imem_rdata    = $urandom;
        step();
      end
    end
    imem_ack     = 1'b0;
    stall        = 1'b0;
    branch_taken = 1'b0;
    if (take) begin
      byte_off = $signed({off, 1'b0});
      m_pc     = (m_pc + 32'(byte_off)) & 32'hFFFF_FFFC;
    end else begin
      m_pc = m_pc + 32'd4;
    end
    m_instret = m_instret + 32'd1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    total++;
    if (pc !== 32'h0 || instr !== 32'h0000_0013 || en !== 4'b0000 || imem_req !== 1'b0 ||
        instr_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset: pc=%h instr=%h en=%b req=%b valid=%b, want 0/00000013/0000/0/0",
               pc, instr, en, imem_req, instr_valid);
    end
    rst_n = 1'b1;
    step();
    m_pc      = 32'h0;
    m_instret = 32'h0;
  endtask

  task automatic test_zero_wait();
    run_instr(0, 0, 0, 0, 0, 1'b0, 12'h0, 32'h0020_81B3);
    total++;
    if (imem_addr !== 32'h4) begin
      bad++;
      $display("FAIL zero_wait_next: addr=%h want 00000004", imem_addr);
    end
  endtask

  task automatic test_mem_wait();
    run_instr(3, 0, 0, 0, 0, 1'b0, 12'h0, 32'hDEAD_BEEF);
  endtask

  task automatic test_branch();
    run_instr(0, 0, 0, 0, 0, 1'b0, 12'h0, $urandom);
    run_instr(1, 0, 0, 0, 0, 1'b0, 12'h0, $urandom);
    run_instr(0, 0, 0, 0, 0, 1'b1, 12'hFFE, $urandom);
    total++;
    if (imem_addr !== 32'h0C) begin
      bad++;
      $display("FAIL branch_back: addr=%h want 0000000c", imem_addr);
    end
    run_instr(0, 0, 0, 0, 0, 1'b0, 12'h0, $urandom);
    run_instr(0, 0, 0, 0, 0, 1'b1, 12'h008, $urandom);
    total++;
    if (imem_addr !== 32'h20) begin
      bad++;
      $display("FAIL branch_fwd: addr=%h want 00000020", imem_addr);
    end
  endtask

  task automatic test_stall();
    run_instr(0, 0, 2, 0, 0, 1'b0, 12'h0, $urandom);
    run_instr(0, 1, 0, 1, 3, 1'b1, 12'h7FE, $urandom);
    run_instr(2, 0, 0, 0, 2, 1'b0, 12'h004, $urandom);
  endtask

  task automatic test_reset_mid();
    m_pc = 32'h20;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    m_pc      = 32'h0;
    m_instret = 32'h0;
    run_instr(0, 0, 0, 0, 0, 1'b1, 12'h020, $urandom);
    imem_ack   = 1'b1;
    imem_rdata = 32'h1234_5678;
    step();
    imem_ack = 1'b0;
    step();
    step();
    total++;
    if (en !== 4'b0100 || pc !== 32'h40) begin
      bad++;
      $display("FAIL mid_pre: en=%b pc=%h want 0100/00000040", en, pc);
    end
    rst_n        = 1'b0;
    imem_ack     = 1'b1;
    imem_rdata   = $urandom;
    branch_taken = 1'b1;
    step();
    total++;
    if (pc !== 32'h0 || en !== 4'b0000 || instr !== 32'h0000_0013 || instr_valid !== 1'b0 ||
        imem_req !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset: pc=%h en=%b instr=%h valid=%b req=%b, want 0/0000/00000013/0/0",
               pc, en, instr, instr_valid, imem_req);
    end
`ifdef FETCH_PERF_CNT_EN
    total++;
    if (instret !== 32'h0) begin
      bad++;
      $display("FAIL mid_reset_instret: got %0d want 0", instret);
    end
`endif
    rst_n        = 1'b1;
    imem_ack     = 1'b0;
    branch_taken = 1'b0;
    step();
    m_pc      = 32'h0;
    m_instret = 32'h0;
  endtask

  task automatic test_wrap();
    run_instr(0, 0, 0, 0, 0, 1'b1, 12'hFFE, $urandom);
    total++;
    if (imem_addr !== 32'hFFFF_FFFC) begin
      bad++;
      $display("FAIL wrap_pre: addr=%h want fffffffc", imem_addr);
    end
    run_instr(1, 0, 0, 0, 0, 1'b0, 12'h0, $urandom);
    total++;
    if (imem_addr !== 32'h0) begin
      bad++;
      $display("FAIL wrap: addr=%h want 00000000", imem_addr);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      run_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                int'($urandom_range(0, 2)), 1'($urandom % 2), 12'($urandom), $urandom);
    end
    run_instr(0, 0, 0, 0, 0, 1'b0, 12'h0, $urandom);
  endtask

  initial begin
    rst_n         = 1'b0;
    imem_ack      = 1'b0;
    imem_rdata    = '0;
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_offset = '0;
    m_pc          = '0;
    m_instret     = '0;
    step();
    test_reset();
    test_zero_wait();
    test_mem_wait();
    test_branch();
    test_stall();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction fetch and phase sequencer that sits directly upstream of the instruction decoder.
- Holds the PC and fetches a 32-bit word from instruction memory over a req/ack handshake.
- Presents the fetched word as `instr`, and drives the one-hot phase bus `en[3:0]` that the decoder and later stages qualify on.
- Computes the next PC as sequential (+4) or as a taken branch (PC + sign-extended B-type offset).

Parameters:
- XLEN, 32, PC and instruction-address width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- imem_req  out  1  fetch request; held until ack.
- imem_addr  out  XLEN  fetch address, equal to pc.
- imem_ack  in  1  memory returns data this cycle.
- imem_rdata  in  32  instruction word, valid with imem_ack.
- stall  in  1  freezes the current execute-side phase.
- branch_taken  in  1  branch resolved taken; sampled in the WB phase.
- branch_offset  in  12  B-type offset[12:1] from the decoder.
- instr  out  32  latched instruction word (decoder input).
- pc  out  XLEN  PC of the instruction in flight.
- en  out  4  one-hot phase: 0000 FETCH, 0001 DEC, 0010 EXE, 0100 MEM, 1000 WB.
- instr_valid  out  1  high while instr holds a fetched word (DEC..WB).

Behaviour:
- Reset is synchronous on rst_n=0. At the next edge: pc=RESET_PC, instr=32'h0000_0013 (NOP), en=0000, imem_req=0, instr_valid=0, state=RST.
- Reset asserted mid-fetch or mid-phase aborts unconditionally. A pending imem_ack is ignored.
- FSM states: RST, FETCH, DEC, EXE, MEM, WB.
- RST: unconditionally goes to FETCH on the next edge.
- FETCH:
  - imem_req=1, imem_addr=pc, en=0000.
  - On imem_ack=1: instr<=imem_rdata, instr_valid<=1, go to DEC.
  - Otherwise stay in FETCH; request held, address stable.
- DEC, EXE, MEM, WB: one cycle each, imem_req=0, en = state encoding.
- stall=1 in DEC..WB holds the state, en, instr and pc. stall is ignored in FETCH and RST.
- WB exit (stall=0):
  - If branch_taken=1: pc <= pc + sext({branch_offset,1'b0}), with result bits [1:0] forced to 00.
  - Otherwise pc <= pc + 4.
  - Arithmetic is modulo 2^XLEN: wrap from 32'hFFFF_FFFC goes to 0 with no flag.
  - Then instr_valid<=0 and go to FETCH.
- Latency: with imem_ack in the same cycle as imem_req, one instruction takes 5 cycles (FETCH, DEC, EXE, MEM, WB). Each memory wait cycle adds 1.
- imem_ack while imem_req=0 is ignored.
- branch_taken outside WB is ignored.
- branch_taken and stall both high in WB: stall wins, and branch_taken is re-sampled on the cycle stall drops.
- All outputs are registered except imem_addr, which is wired from pc.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- When defined: adds output `instret[31:0]`.
  - Reset value 0.
  - Increments by 1 on each WB exit.
  - Wraps at 2^32.
  - Not incremented while stalled.
- When undefined: the port and counter do not exist; all other behaviour is identical.

Decomposition:
- Shared package fetch_pkg holds:
  - phase constants EN_FETCH=4'b0000, EN_DEC=4'b0001, EN_EXE=4'b0010, EN_MEM=4'b0100, EN_WB=4'b1000;
  - NOP_INSTR=32'h0000_0013;
  - the FSM state typedef.
- One sub-module: fetch_pc_next.
  - Combinational inputs: pc, branch_taken, branch_offset.
  - Output: next pc, including sign extension and forcing bits [1:0] to 00.

Test Plan:
- Reset then zero-wait memory returning 32'h0020_81B3 at addr 0 → en sequence 0000,0001,0010,0100,1000; instr=32'h0020_81B3 from DEC onward; next imem_addr=0x4.
- imem_ack delayed 3 cycles → imem_req high 4 cycles, imem_addr stable at 0x0; DEC entered the cycle after ack.
- branch_offset=12'hFFE (−4 bytes), branch_taken=1 in WB at pc=0x10 → next imem_addr=0x0C; branch_offset=12'h008 → next imem_addr=0x20.
- stall=1 for 2 cycles during EXE → en held at 0010 for 3 cycles total; instr and pc unchanged.
- rst_n=0 asserted in MEM at pc=0x40 → next edge pc=RESET_PC, en=0000, instr=NOP, instr_valid=0; a simultaneous imem_ack is ignored.
- pc=32'hFFFF_FFFC, sequential WB exit → pc=0. With FETCH_PERF_CNT_EN defined, instret increments exactly once per instruction.
